// File: rtl/traffic_pkg.sv
// Shared types and constants for the crossroad phase sequencer.
// State codes, light-head codes, config selectors, light decode helper.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_NSG   = 3'd0,
        S_NSY   = 3'd1,
        S_EWG   = 3'd2,
        S_EWY   = 3'd3,
        S_NIGHT = 3'd4
    } state_e;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    localparam logic [1:0] SEL_NSG = 2'd0;
    localparam logic [1:0] SEL_NSY = 2'd1;
    localparam logic [1:0] SEL_EWG = 2'd2;
    localparam logic [1:0] SEL_EWY = 2'd3;

    // Returns {ns_head, ew_head} for a state and flash phase.
    function automatic logic [5:0] head_lights(state_e s, logic f);
        logic [5:0] r;
        r = {L_OFF, L_OFF};
        unique case (s)
            S_NSG:   r = {L_GRN, L_RED};
            S_NSY:   r = {L_YEL, L_RED};
            S_EWG:   r = {L_RED, L_GRN};
            S_EWY:   r = {L_RED, L_YEL};
            S_NIGHT: r = f ? {L_YEL, L_YEL} : {L_OFF, L_OFF};
            default: r = {L_OFF, L_OFF};
        endcase
        return r;
    endfunction

    function automatic state_e next_phase(state_e s);
        state_e n;
        n = S_NSG;
        unique case (s)
            S_NSG:   n = S_NSY;
            S_NSY:   n = S_EWG;
            S_EWG:   n = S_EWY;
            default: n = S_NSG;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control/status bundle between the controller and its environment.
// master: drives TICK/EN/NIGHT/PED_REQ/CFG_*; slave: drives lights/timer/phase.
interface traffic_phase_ctrl_if #(
    parameter int W = 6
);
    logic         TICK;
    logic         EN;
    logic         NIGHT;
    logic         PED_REQ;
    logic         CFG_WE;
    logic [1:0]   CFG_SEL;
    logic [W-1:0] CFG_DATA;
    logic [2:0]   NS_LIGHT;
    logic [2:0]   EW_LIGHT;
    logic [W-1:0] TIME_LEFT;
    logic [2:0]   PHASE;
    logic         PHASE_END;

    modport master (
        output TICK, EN, NIGHT, PED_REQ, CFG_WE, CFG_SEL, CFG_DATA,
        input  NS_LIGHT, EW_LIGHT, TIME_LEFT, PHASE, PHASE_END
    );

    modport slave (
        input  TICK, EN, NIGHT, PED_REQ, CFG_WE, CFG_SEL, CFG_DATA,
        output NS_LIGHT, EW_LIGHT, TIME_LEFT, PHASE, PHASE_END
    );
endinterface

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Loadable W-bit down counter holding the seconds left in a phase.
// Ports: clk, rst, load/ld_val (load wins), dec; count, is_one.
module phase_timer #(
    parameter int W       = 6,
    parameter int RST_VAL = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_one
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = ld_val;
        end else if (dec) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign is_one = (count_q == W'(1));
endmodule

// File: rtl/traffic_phase_ctrl.sv
// Crossroad phase sequencer with pedestrian shortening, night flash and
// writable durations. Ports: CLK, RST, bus (slave side of the ctrl interface).
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int W       = 6,
    parameter int G_NS    = 30,
    parameter int Y_NS    = 3,
    parameter int G_EW    = 20,
    parameter int Y_EW    = 3,
    parameter int PED_MIN = 5
) (
    input logic                 CLK,
    input logic                 RST,
    traffic_phase_ctrl_if.slave bus
);
    state_e       state_q, state_d;
    logic         flash_q, flash_d;
    logic         ped_q, ped_d;
    logic [W-1:0] dur_q [4];
    logic [W-1:0] dur_d [4];
    logic [2:0]   ns_q, ns_d;
    logic [2:0]   ew_q, ew_d;

    logic         t_load;
    logic [W-1:0] t_val;
    logic         t_dec;
    logic [W-1:0] t_count;
    logic         t_one;
    logic         tick_en;
    logic         green;
    state_e       nxt;

    phase_timer #(
        .W       (W),
        .RST_VAL (G_NS)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .load   (t_load),
        .ld_val (t_val),
        .dec    (t_dec),
        .count  (t_count),
        .is_one (t_one)
    );

    assign tick_en = bus.TICK & bus.EN;
    assign green   = (state_q == S_NSG) || (state_q == S_EWG);
    assign nxt     = next_phase(state_q);

    always_comb begin
        state_d = state_q;
        flash_d = flash_q;
        ped_d   = ped_q | bus.PED_REQ;
        t_load  = 1'b0;
        t_val   = t_count;
        t_dec   = 1'b0;
        dur_d   = dur_q;

        // Zero duration would never reach is_one, so clamp to 1.
        if (bus.CFG_WE) begin
            dur_d[bus.CFG_SEL] = (bus.CFG_DATA == '0) ? W'(1) : bus.CFG_DATA;
        end

        if (bus.NIGHT) begin
            state_d = S_NIGHT;
            ped_d   = 1'b0;
            t_load  = 1'b1;
            t_val   = '0;
            flash_d = (state_q == S_NIGHT) ? (flash_q ^ bus.TICK) : 1'b1;
        end else if (state_q == S_NIGHT) begin
            state_d = S_NSG;
            flash_d = 1'b0;
            t_load  = 1'b1;
            t_val   = dur_q[SEL_NSG];
        end else if (tick_en && t_one) begin
            state_d = nxt;
            t_load  = 1'b1;
            t_val   = dur_q[nxt[1:0]];
            if (nxt == S_NSY || nxt == S_EWY) begin
                ped_d = 1'b0;
            end
        end else if (tick_en && green && ped_q && (t_count > W'(PED_MIN))) begin
            t_load = 1'b1;
            t_val  = W'(PED_MIN);
        end else if (tick_en) begin
            t_dec = 1'b1;
        end

        {ns_d, ew_d} = head_lights(state_d, flash_d);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_NSG;
            flash_q <= 1'b0;
            ped_q   <= 1'b0;
            dur_q[SEL_NSG] <= W'(G_NS);
            dur_q[SEL_NSY] <= W'(Y_NS);
            dur_q[SEL_EWG] <= W'(G_EW);
            dur_q[SEL_EWY] <= W'(Y_EW);
            ns_q    <= L_GRN;
            ew_q    <= L_RED;
        end else begin
            state_q <= state_d;
            flash_q <= flash_d;
            ped_q   <= ped_d;
            dur_q   <= dur_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
        end
    end

    assign bus.NS_LIGHT  = ns_q;
    assign bus.EW_LIGHT  = ew_q;
    assign bus.TIME_LEFT = t_count;
    assign bus.PHASE     = state_q;
    assign bus.PHASE_END = bus.TICK & bus.EN & ~bus.NIGHT &
                           (state_q != S_NIGHT) & t_one;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with short phase durations.
// Ticks every 4 clocks; outputs sampled on the falling clock edge.
module tb_traffic_phase_ctrl;
    localparam int W = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic pe;

    traffic_phase_ctrl_if #(.W(W)) tif ();

    traffic_phase_ctrl #(
        .W       (W),
        .G_NS    (4),
        .Y_NS    (2),
        .G_EW    (3),
        .Y_EW    (2),
        .PED_MIN (1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (tif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic state_chk(input string tag, input int ph, input int tl,
                             input int ns, input int ew);
        chk({tag, ".phase"}, 32'(tif.PHASE), 32'(ph));
        chk({tag, ".time"},  32'(tif.TIME_LEFT), 32'(tl));
        chk({tag, ".ns"},    32'(tif.NS_LIGHT), 32'(ns));
        chk({tag, ".ew"},    32'(tif.EW_LIGHT), 32'(ew));
    endtask

    task automatic do_tick(output logic phase_end);
        @(negedge CLK);
        tif.TICK = 1'b1;
        #1 phase_end = tif.PHASE_END;
        @(negedge CLK);
        tif.TICK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        logic p;
        for (int i = 0; i < n; i++) do_tick(p);
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [W-1:0] d);
        @(negedge CLK);
        tif.CFG_WE   = 1'b1;
        tif.CFG_SEL  = sel;
        tif.CFG_DATA = d;
        @(negedge CLK);
        tif.CFG_WE   = 1'b0;
    endtask

    initial begin
        int exp_tl [11];
        int exp_ph [11];
        int pe_at  [11];
        exp_tl = '{4, 3, 2, 1, 2, 1, 3, 2, 1, 2, 1};
        exp_ph = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 3, 3};
        pe_at  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};

        tif.TICK = 1'b0;
        tif.EN = 1'b1;
        tif.NIGHT = 1'b0;
        tif.PED_REQ = 1'b0;
        tif.CFG_WE = 1'b0;
        tif.CFG_SEL = 2'd0;
        tif.CFG_DATA = '0;
        @(negedge CLK);
        @(negedge CLK);
        state_chk("reset", 0, 4, 1, 4);
        RST = 1'b0;
        @(negedge CLK);

        // Full cycle through all four phases.
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("cyc%0d.time", i), 32'(tif.TIME_LEFT), 32'(exp_tl[i]));
            chk($sformatf("cyc%0d.phase", i), 32'(tif.PHASE), 32'(exp_ph[i]));
            do_tick(pe);
            chk($sformatf("cyc%0d.pend", i), 32'(pe), 32'(pe_at[i]));
        end
        state_chk("wrap", 0, 4, 1, 4);

        // Duration write does not touch the running count.
        cfg(2'd2, 6'd6);
        state_chk("cfg6.hold", 0, 4, 1, 4);
        ticks(4);
        state_chk("cfg6.nsy", 1, 2, 2, 4);
        ticks(2);
        state_chk("cfg6.ewg", 2, 6, 4, 1);
        cfg(2'd2, 6'd0);
        state_chk("cfg0.hold", 2, 6, 4, 1);
        ticks(6);
        state_chk("cfg0.ewy", 3, 2, 4, 2);
        ticks(2);
        state_chk("cfg0.nsg", 0, 4, 1, 4);

        // Pedestrian request shortens green to PED_MIN.
        @(negedge CLK);
        tif.PED_REQ = 1'b1;
        @(negedge CLK);
        tif.PED_REQ = 1'b0;
        chk("ped.noeffect", 32'(tif.TIME_LEFT), 32'd4);
        ticks(1);
        state_chk("ped.short", 0, 1, 1, 4);
        ticks(1);
        state_chk("ped.nsy", 1, 2, 2, 4);

        // Freeze with EN low.
        tif.EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_tick(pe);
            chk($sformatf("frz%0d.pend", i), 32'(pe), 32'd0);
        end
        state_chk("frz", 1, 2, 2, 4);
        tif.EN = 1'b1;
        ticks(1);
        state_chk("resume", 1, 1, 2, 4);
        ticks(1);
        state_chk("ewg1", 2, 1, 4, 1);

        // Night flashing mode entered from EW green.
        @(negedge CLK);
        tif.NIGHT = 1'b1;
        @(negedge CLK);
        state_chk("night.in", 4, 0, 2, 2);
        do_tick(pe);
        chk("night.pend", 32'(pe), 32'd0);
        state_chk("night.off", 4, 0, 0, 0);
        ticks(1);
        state_chk("night.on", 4, 0, 2, 2);
        tif.NIGHT = 1'b0;
        @(negedge CLK);
        state_chk("night.out", 0, 4, 1, 4);

        // Asynchronous reset mid EW yellow restores defaults.
        cfg(2'd0, 6'd9);
        ticks(4);
        state_chk("pre.nsy", 1, 2, 2, 4);
        ticks(2);
        ticks(1);
        state_chk("pre.ewy", 3, 2, 4, 2);
        @(negedge CLK);
        #3 RST = 1'b1;
        #1 state_chk("rst.async", 0, 4, 1, 4);
        @(negedge CLK);
        RST = 1'b0;
        ticks(6);
        state_chk("rst.ewg", 2, 3, 4, 1);
        ticks(5);
        state_chk("rst.nsg", 0, 4, 1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
